multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset core: R-type, ADDI, SLTIU, BEQ, LUI, ORI, BNE. It sequences the shared datapath (one ALU, one memory port, IR, PC) through fetch, decode, execute, branch and write-back. It produces per-cycle strobes and ALU selects in place of single-cycle opcode decoding. It also keeps a retired-instruction counter and flags illegal opcodes.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/multicycle_ctrl.sv | 137 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
// Holds opcodes, ALU operation codes, ALU B-operand selects and FSM states.
package cpu_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SRCB_W   = 2;
  localparam int unsigned STATE_W  = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

  // Same values as the single-cycle decoder so the ALU is shared unchanged.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_R_TYPE = 3'd0,
    ALU_ADDI   = 3'd1,
    ALU_SLTIU  = 3'd2,
    ALU_BEQ    = 3'd3,
    ALU_LUI    = 3'd4,
    ALU_ORI    = 3'd5,
    ALU_BNE    = 3'd6
  } alu_op_e;

  typedef enum logic [SRCB_W-1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  typedef enum logic [STATE_W-1:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX_R = 3'd2,
    S_EX_I = 3'd3,
    S_BR   = 3'd4,
    S_WB   = 3'd5,
    S_ILL  = 3'd6
  } state_e;

  // ALU operation for an immediate-class opcode; ADDI is the fallback.
  function automatic alu_op_e imm_alu_op(input logic [OP_W-1:0] op);
    alu_op_e res;
    res = ALU_ADDI;
    case (op)
      OP_SLTIU: res = ALU_SLTIU;
      OP_LUI:   res = ALU_LUI;
      OP_ORI:   res = ALU_ORI;
      default:  res = ALU_ADDI;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/branch/write-back,
// counts retired instructions and traps unsupported opcodes.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                imem_ready_i,
  input  logic                zero_i,
  output logic                IRWrite_o,
  output logic                PCWrite_o,
  output logic                PCSrc_o,
  output logic                ALUSrcA_o,
  output logic [SRCB_W-1:0]   ALUSrcB_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic                RegDst_o,
  output logic                RegWrite_o,
  output logic                illegal_o,
  output logic [STATE_W-1:0]  state_o,
  output logic [CNT_W-1:0]    retired_o
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [CNT_W-1:0] retired_q;
  logic            illegal_q;

  logic    irw, pcw, pcsrc, asa, regdst, regw, retire;
  srcb_e   srcb;
  alu_op_e alu_op;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IF;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= instr_op_i;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (state_d == S_ILL) illegal_q <= 1'b1;
    end
  end

  // Next-state and Moore decode; IF strobes and BR PCWrite follow their inputs.
  always_comb begin
    state_d = state_q;
    irw     = 1'b0;
    pcw     = 1'b0;
    pcsrc   = 1'b0;
    asa     = 1'b0;
    srcb    = SRCB_REG;
    alu_op  = ALU_R_TYPE;
    regdst  = 1'b0;
    regw    = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IF: begin
        srcb   = SRCB_FOUR;
        alu_op = ALU_ADDI;
        irw    = imem_ready_i;
        pcw    = imem_ready_i;
        if (imem_ready_i) state_d = S_ID;
      end
      S_ID: begin
        srcb   = SRCB_IMM_SH2;
        alu_op = ALU_ADDI;
        case (instr_op_i)
          OP_RTYPE:                         state_d = S_EX_R;
          OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: state_d = S_EX_I;
          OP_BEQ, OP_BNE:                   state_d = S_BR;
          default:                          state_d = S_ILL;
        endcase
      end
      S_EX_R: begin
        asa     = 1'b1;
        srcb    = SRCB_REG;
        alu_op  = ALU_R_TYPE;
        state_d = S_WB;
      end
      S_EX_I: begin
        asa     = 1'b1;
        srcb    = SRCB_IMM;
        alu_op  = imm_alu_op(op_q);
        state_d = S_WB;
      end
      S_BR: begin
        asa    = 1'b1;
        srcb   = SRCB_REG;
        pcsrc  = 1'b1;
        retire = 1'b1;
        if (op_q == OP_BNE) begin
          alu_op = ALU_BNE;
          pcw    = ~zero_i;
        end else begin
          alu_op = ALU_BEQ;
          pcw    = zero_i;
        end
        state_d = S_IF;
      end
      S_WB: begin
        regw   = 1'b1;
        asa    = 1'b1;
        retire = 1'b1;
        if (op_q == OP_RTYPE) begin
          regdst = 1'b1;
          srcb   = SRCB_REG;
          alu_op = ALU_R_TYPE;
        end else begin
          srcb   = SRCB_IMM;
          alu_op = imm_alu_op(op_q);
        end
        state_d = S_IF;
      end
      S_ILL:   state_d = S_ILL;
      default: state_d = S_IF;
    endcase
  end

  // Strobes are masked during reset so a mid-instruction reset writes nothing.
  assign IRWrite_o  = irw & rst_i;
  assign PCWrite_o  = pcw & rst_i;
  assign RegWrite_o = regw & rst_i;
  assign PCSrc_o    = pcsrc;
  assign ALUSrcA_o  = asa;
  assign ALUSrcB_o  = srcb;
  assign ALU_op_o   = alu_op;
  assign RegDst_o   = regdst;
  assign illegal_o  = illegal_q;
  assign state_o    = state_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXR = 3'd2, ST_EXI = 3'd3;
  localparam logic [2:0] ST_BR = 3'd4, ST_WB = 3'd5, ST_ILL = 3'd6;
  localparam logic [5:0] O_R = 6'b000000, O_ADDI = 6'b001000, O_SLTIU = 6'b001011;
  localparam logic [5:0] O_LUI = 6'b001111, O_ORI = 6'b001101, O_BEQ = 6'b000100;
  localparam logic [5:0] O_BNE = 6'b000101, O_LW = 6'b100011;

  typedef struct packed {
    logic [2:0]  st;
    logic        irw, pcw, pcsrc, asa;
    logic [1:0]  asb;
    logic [2:0]  aop;
    logic        rd, rw, ill;
    logic [31:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i, imem_ready_i, zero_i;
  logic [5:0] instr_op_i;

  logic irw, pcw, pcsrc, asa, rd, rw, ill;
  logic [1:0] asb;
  logic [2:0] aop, st;
  logic [31:0] ret;
  logic irw4, pcw4, pcsrc4, asa4, rd4, rw4, ill4;
  logic [1:0] asb4;
  logic [2:0] aop4, st4;
  logic [3:0] ret4;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic [31:0] exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl u_dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .imem_ready_i(imem_ready_i),
    .zero_i(zero_i), .IRWrite_o(irw), .PCWrite_o(pcw), .PCSrc_o(pcsrc),
    .ALUSrcA_o(asa), .ALUSrcB_o(asb), .ALU_op_o(aop), .RegDst_o(rd),
    .RegWrite_o(rw), .illegal_o(ill), .state_o(st), .retired_o(ret)
  );

  multicycle_ctrl #(.CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .imem_ready_i(imem_ready_i),
    .zero_i(zero_i), .IRWrite_o(irw4), .PCWrite_o(pcw4), .PCSrc_o(pcsrc4),
    .ALUSrcA_o(asa4), .ALUSrcB_o(asb4), .ALU_op_o(aop4), .RegDst_o(rd4),
    .RegWrite_o(rw4), .illegal_o(ill4), .state_o(st4), .retired_o(ret4)
  );

  function automatic string fmt(input vec_t v);
    return $sformatf("st=%0d irw=%0b pcw=%0b pcsrc=%0b asa=%0b asb=%b aop=%0d rd=%0b rw=%0b ill=%0b ret=%0d",
                     v.st, v.irw, v.pcw, v.pcsrc, v.asa, v.asb, v.aop, v.rd, v.rw, v.ill, v.ret);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic push_exp(input string nm, input logic [2:0] s, input logic e_irw, e_pcw,
                          e_pcsrc, e_asa, input logic [1:0] e_asb, input logic [2:0] e_aop,
                          input logic e_rd, e_rw, e_ill);
    vec_t e;
    e.st = s; e.irw = e_irw; e.pcw = e_pcw; e.pcsrc = e_pcsrc; e.asa = e_asa;
    e.asb = e_asb; e.aop = e_aop; e.rd = e_rd; e.rw = e_rw; e.ill = e_ill; e.ret = exp_ret;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One clock of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input logic r, rdy, input logic [5:0] op, input logic z, input string nm,
                     input logic [2:0] s, input logic e_irw, e_pcw, e_pcsrc, e_asa,
                     input logic [1:0] e_asb, input logic [2:0] e_aop,
                     input logic e_rd, e_rw, e_ill);
    @(posedge clk);
    #1;
    rst_i = r; imem_ready_i = rdy; instr_op_i = op; zero_i = z;
    push_exp(nm, s, e_irw, e_pcw, e_pcsrc, e_asa, e_asb, e_aop, e_rd, e_rw, e_ill);
  endtask

  task automatic c_rst(input logic [5:0] op);
    cyc(0, 1, op, 0, "reset", ST_IF, 0, 0, 0, 0, 2'b01, 3'd1, 0, 0, 0);
  endtask

  task automatic c_if(input logic rdy, input logic [5:0] op);
    cyc(1, rdy, op, 0, "fetch", ST_IF, rdy, rdy, 0, 0, 2'b01, 3'd1, 0, 0, 0);
  endtask

  task automatic c_id(input logic [5:0] op);
    cyc(1, 1, op, 1, "decode", ST_ID, 0, 0, 0, 0, 2'b11, 3'd1, 0, 0, 0);
  endtask

  task automatic itype(input logic [5:0] op, input logic [2:0] a, input string nm);
    c_if(1, op);
    c_id(op);
    cyc(1, 1, op, 0, {nm, "_ex"}, ST_EXI, 0, 0, 0, 1, 2'b10, a, 0, 0, 0);
    cyc(1, 1, op, 0, {nm, "_wb"}, ST_WB, 0, 0, 0, 1, 2'b10, a, 0, 1, 0);
    exp_ret++;
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic [2:0] a,
                        input logic e_pcw, input string nm);
    c_if(1, op);
    c_id(op);
    cyc(1, 1, op, z, nm, ST_BR, 0, e_pcw, 1, 1, 2'b00, a, 0, 0, 0);
    exp_ret++;
  endtask

  // Asynchronous reset pulse landing mid-cycle in the given state.
  task automatic async_rst(input logic [2:0] pre, input string nm);
    @(posedge clk);
    #1;
    imem_ready_i = 1'b1;
    chk({nm, "_pre_state"}, 32'(st), 32'(pre));
    #1 rst_i = 1'b0;
    #1;
    chk({nm, "_state"}, 32'(st), 32'(ST_IF));
    chk({nm, "_strobes"}, 32'({irw, pcw, rw}), 32'd0);
    chk({nm, "_retired"}, ret, 32'd0);
    chk({nm, "_illegal"}, 32'(ill), 32'd0);
    exp_ret = 0;
    push_exp({nm, "_held"}, ST_IF, 0, 0, 0, 0, 2'b01, 3'd1, 0, 0, 0);
  endtask

  initial begin : monitor
    vec_t e, a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{st, irw, pcw, pcsrc, asa, asb, aop, rd, rw, ill, ret};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %s expected %s", nm, fmt(a), fmt(e));
        end
        a = '{st4, irw4, pcw4, pcsrc4, asa4, asb4, aop4, rd4, rw4, ill4, 32'(ret4)};
        e.ret = e.ret & 32'hF;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s_cnt4: got %s expected %s", nm, fmt(a), fmt(e));
        end
      end
    end
  end

  initial begin : stimulus
    rst_i = 1'b0; imem_ready_i = 1'b1; instr_op_i = O_R; zero_i = 1'b0;
    c_rst(O_R);
    c_rst(O_R);
    // R-type, released with fetch data ready
    c_if(1, O_R);
    c_id(O_R);
    cyc(1, 1, O_R, 0, "r_ex", ST_EXR, 0, 0, 0, 1, 2'b00, 3'd0, 0, 0, 0);
    cyc(1, 1, O_R, 0, "r_wb", ST_WB, 0, 0, 0, 1, 2'b00, 3'd0, 1, 1, 0);
    exp_ret = 1;
    // ADDI with a two-cycle fetch stall; opcode input changes after ID
    c_if(0, O_ADDI);
    c_if(0, O_ADDI);
    c_if(1, O_ADDI);
    c_id(O_ADDI);
    cyc(1, 1, O_LW, 0, "addi_ex", ST_EXI, 0, 0, 0, 1, 2'b10, 3'd1, 0, 0, 0);
    cyc(1, 1, O_LW, 0, "addi_wb", ST_WB, 0, 0, 0, 1, 2'b10, 3'd1, 0, 1, 0);
    exp_ret = 2;
    branch(O_BEQ, 1, 3'd3, 1, "beq_taken");
    branch(O_BEQ, 0, 3'd3, 0, "beq_not");
    branch(O_BNE, 0, 3'd6, 1, "bne_taken");
    branch(O_BNE, 1, 3'd6, 0, "bne_not");
    itype(O_SLTIU, 3'd2, "sltiu");
    itype(O_LUI, 3'd4, "lui");
    // Unsupported opcode traps until reset
    c_if(1, O_LW);
    c_id(O_LW);
    for (int i = 0; i < 20; i++)
      cyc(1, 1, O_LW, 1'(i), "ill", ST_ILL, 0, 0, 0, 0, 2'b00, 3'd0, 0, 0, 1);
    async_rst(ST_ILL, "ill_rst");
    // Reset in EX_I aborts the write-back
    c_if(1, O_ADDI);
    c_id(O_ADDI);
    async_rst(ST_EXI, "exi_rst");
    // 16 back-to-back ORI wrap the 4-bit counter
    for (int i = 0; i < 16; i++) itype(O_ORI, 3'd5, "ori");
    c_if(0, O_ORI);
    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
